multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Next-generation RV32I controller: replaces per-instruction combinational decode with a multi-cycle Moore FSM (fetch/decode/execute/memory/writeback) driving a shared-ALU, single-memory datapath.
- Adds variable-latency memory handshake, timeout trap, illegal-opcode trap, JALR/AUIPC support and a retired-instruction counter.
- Sits between the instruction register and the datapath muxes/enables.

Parameters:
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready in FETCH/MEM before trapping; must be >= 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- instruction, input, 32, IR contents; stable from the cycle after ir_write.
- mem_ready, input, 1, memory completes the current read/write this cycle.
- ir_write, output, 1, latch memory data into IR; datapath also latches OldPC = PC.
- pc_write, output, 1, unconditional PC update.
- pc_write_cond, output, 1, PC update if ALU zero/compare true.
- pc_src, output, 2, PC source: 00 ALU result, 01 ALUOut register.
- i_or_d, output, 1, memory address: 0 PC, 1 ALUOut.
- mem_read, output, 1, memory read request.
- mem_write, output, 1, memory write request.
- alu_src_a, output, 2, ALU A operand: 00 PC, 01 rs1 (A reg), 10 OldPC.
- alu_src_b, output, 2, ALU B operand: 00 rs2 (B reg), 01 constant 4, 10 immediate.
- alu_op, output, 2, ALU op: 00 add, 01 branch compare (funct3), 10 funct3/funct7 decode, 11 pass B.
- reg_write, output, 1, register file write enable.
- mem_to_reg, output, 2, rd data source: 00 MDR, 01 ALUOut, 10 PC.
- illegal_instr, output, 1, sticky; set on trap from DECODE.
- mem_timeout, output, 1, sticky; set on memory timeout.
- state, output, 3, current FSM state, for debug.
- retired, output, CNT_W, count of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset: state=IDLE; every strobe/select output 0; illegal_instr, mem_timeout, retired and wait counter all 0.
- Outputs are Moore: decoded from state plus a class register latched in DECODE. Any signal not listed for a state is 0.
- IDLE: all outputs 0 -> FETCH on the next clock.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - On mem_ready: ir_write=1 and pc_write=1 (pc_src=00) in the same cycle -> DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch class from instruction[6:0]: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - Drive alu_src_a=10, alu_src_b=10, alu_op=00 (branch/JAL target into ALUOut).
  - Unknown opcode or instruction[1:0]!=11 -> TRAP with illegal_instr=1; otherwise -> EXEC.
- EXEC, per class:
  - R: a=01, b=00, op=10 -> WB.
  - I: a=01, b=10, op=10 -> WB.
  - L/S: a=01, b=10, op=00 -> MEM.
  - B: a=01, b=00, op=01, pc_write_cond=1, pc_src=01 -> FETCH; retires.
  - JAL: pc_write=1, pc_src=01, reg_write=1, mem_to_reg=10 -> FETCH; retires.
  - JALR: a=01, b=10, op=00, pc_write=1, pc_src=00, reg_write=1, mem_to_reg=10 -> FETCH; retires. rd receives the pre-update PC (= instruction address + 4).
  - LUI: b=10, op=11 -> WB.
  - AUIPC: a=10, b=10, op=00 -> WB.
- MEM: i_or_d=1; mem_read=1 for L, mem_write=1 for S. Hold until mem_ready.
  - L -> WB.
  - S -> FETCH; retires.
- WB: reg_write=1; mem_to_reg=00 for L, 01 otherwise -> FETCH; retires.
- Retire: retired increments by 1 on the clock edge leaving the retiring state.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle in FETCH/MEM without mem_ready.
  - If it reaches MEM_TIMEOUT with mem_ready still low -> TRAP with mem_timeout=1.
  - mem_ready in the same cycle the limit is reached takes priority: normal transition, no trap.
- TRAP: all strobes 0; stays until reset_n asserted. Flags and retired hold their values.
- Reset asserted mid-instruction: immediate return to the reset values. No partial write completes after reset_n falls.

Test Plan:
- Reset, then mem_ready=1 always, instruction=0x00500093 (addi x1,x0,5) -> state sequence 0,1,2,3,5,1; reg_write=1 with mem_to_reg=01 in WB; retired=1.
- LW 0x0000A103 with mem_ready held low 3 cycles in MEM -> mem_read=1, i_or_d=1 held 4 cycles; WB asserts mem_to_reg=00; retired increments once.
- BEQ 0x00000463 -> pc_write_cond=1, pc_src=01 in EXEC; FETCH follows; no reg_write in any cycle.
- JALR 0x000080E7 -> EXEC shows pc_write=1, pc_src=00, reg_write=1, mem_to_reg=10, alu_src_a=01, alu_src_b=10.
- Opcode 0x0000007F -> TRAP after DECODE; illegal_instr=1; all strobes 0 for 20 cycles; reset clears the flag.
- MEM_TIMEOUT=15 with mem_ready=0 in FETCH -> TRAP with mem_timeout=1 after the limit. Repeat with mem_ready raised exactly on the limit cycle -> no trap, DECODE follows. Separately, reset_n pulsed low during MEM of a store -> mem_write drops immediately, state=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: Moore outputs from state plus the class latched in DECODE.
// Memory phases wait on mem_ready; a bounded wait traps to TRAP, as does an unknown opcode.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instruction,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             illegal_instr,
  output logic             mem_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [3:0] C_R     = 4'd0;
  localparam logic [3:0] C_I     = 4'd1;
  localparam logic [3:0] C_L     = 4'd2;
  localparam logic [3:0] C_S     = 4'd3;
  localparam logic [3:0] C_B     = 4'd4;
  localparam logic [3:0] C_LUI   = 4'd5;
  localparam logic [3:0] C_AUIPC = 4'd6;
  localparam logic [3:0] C_JAL   = 4'd7;
  localparam logic [3:0] C_JALR  = 4'd8;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]        state_q, next_state;
  logic [3:0]        cls_q, dec_cls;
  logic              dec_ok;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting, timed_out, retire_now;
  logic              unused_ir_bits;

  assign unused_ir_bits = ^instruction[31:7];
  assign state          = state_q;
  assign waiting        = (state_q == S_FETCH) || (state_q == S_MEM);
  // mem_ready on the limit cycle wins over the timeout
  assign timed_out      = waiting && !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    dec_cls = C_R;
    dec_ok  = 1'b1;
    case (instruction[6:0])
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_L;
      7'b0100011: dec_cls = C_S;
      7'b1100011: dec_cls = C_B;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      default:    dec_ok  = 1'b0;
    endcase
    if (instruction[1:0] != 2'b11) dec_ok = 1'b0;
  end

  always_comb begin
    next_state = state_q;
    retire_now = 1'b0;
    case (state_q)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      next_state = S_DECODE;
        else if (timed_out) next_state = S_TRAP;
      end
      S_DECODE: next_state = dec_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (cls_q)
          C_R, C_I, C_LUI, C_AUIPC: next_state = S_WB;
          C_L, C_S:                 next_state = S_MEM;
          default: begin
            next_state = S_FETCH;
            retire_now = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == C_L) begin
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
            retire_now = 1'b1;
          end
        end else if (timed_out) begin
          next_state = S_TRAP;
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        retire_now = 1'b1;
      end
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cls_q         <= C_R;
      wait_cnt      <= '0;
      illegal_instr <= 1'b0;
      mem_timeout   <= 1'b0;
      retired       <= '0;
    end else begin
      state_q <= next_state;
      if (state_q == S_DECODE && dec_ok) cls_q <= dec_cls;
      // Exits from FETCH/MEM happen only on mem_ready or trap, so the count is zero on every entry
      if (waiting && !mem_ready && !timed_out) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                     wait_cnt <= '0;
      if (state_q == S_DECODE && !dec_ok) illegal_instr <= 1'b1;
      if (timed_out)                       mem_timeout   <= 1'b1;
      if (retire_now)                      retired       <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            alu_src_a = 2'b01;
            alu_op    = 2'b10;
          end
          C_I: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
          end
          C_L, C_S: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
          end
          C_B: begin
            alu_src_a     = 2'b01;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
          end
          C_JAL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
          end
          C_JALR: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
          end
          C_LUI: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
          end
          C_AUIPC: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (cls_q == C_L);
        mem_write = (cls_q == C_S);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_L) ? 2'b00 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: an instruction-level model queues the expected per-cycle controls,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_unit;

  localparam int LIMIT = 15;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, TRAP = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
  logic        illegal_instr, mem_timeout;
  logic [2:0]  state;
  logic [31:0] retired;

  multicycle_control_unit #(.MEM_TIMEOUT(LIMIT), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
    .mem_timeout(mem_timeout), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
    logic        ill;
    logic        tmo;
  } obs_t;

  typedef struct packed {
    obs_t        v;
    logic [63:0] tag;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ret_m = '0;
  logic        ill_m = 1'b0;
  logic        tmo_m = 1'b0;
  logic        rst_drive = 1'b0;
  logic [31:0] cur_ins = '0;

  // {ir_write, pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, a, b, op, reg_write, mem_to_reg}
  function automatic logic [16:0] mk(int ir, int pw, int pwc, int ps, int iod, int mr, int mw,
                                     int a, int b, int op, int rw, int m2r);
    return {1'(ir), 1'(pw), 1'(pwc), 2'(ps), 1'(iod), 1'(mr), 1'(mw),
            2'(a), 2'(b), 2'(op), 1'(rw), 2'(m2r)};
  endfunction

  localparam logic [16:0] Z = '0;

  task automatic cyc(input logic rdy, input logic [2:0] st, input logic [16:0] c, input logic [63:0] tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n     = rst_drive;
    instruction = cur_ins;
    mem_ready   = rdy;
    e.v.st  = st;
    e.v.ctl = c;
    e.v.ret = ret_m;
    e.v.ill = ill_m;
    e.v.tmo = tmo_m;
    e.tag   = tag;
    q.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Waits w cycles for the memory; gives up after LIMIT idle cycles plus one more without ready.
  task automatic wait_ph(input int w, input logic [2:0] st, input logic [16:0] busy,
                         input logic [16:0] done, input logic [63:0] tag, output logic trapped);
    int  k = 0;
    logic fin = 1'b0;
    trapped = 1'b0;
    while (!fin) begin
      if (k == w) begin
        cyc(1'b1, st, done, tag);
        fin = 1'b1;
      end else begin
        cyc(1'b0, st, busy, tag);
        if (k == LIMIT) begin
          tmo_m   = 1'b1;
          trapped = 1'b1;
          fin     = 1'b1;
        end
      end
      k++;
    end
  endtask

  task automatic do_reset();
    rst_drive = 1'b0;
    ret_m = '0;
    ill_m = 1'b0;
    tmo_m = 1'b0;
    cyc(rnd(), IDLE, Z, "RESET");
    cyc(rnd(), IDLE, Z, "RESET");
    rst_drive = 1'b1;
    cyc(rnd(), IDLE, Z, "RELEASE");
  endtask

  task automatic trap_hold(input int n);
    repeat (n) cyc(rnd(), TRAP, Z, "TRAP");
  endtask

  // One instruction from its first FETCH cycle; stopped=1 if it trapped or was cut by reset.
  task automatic run(input logic [31:0] ins, input int fw, input int mw, input int rst_mem,
                     output logic stopped);
    logic [6:0]  op;
    logic [16:0] ex;
    logic        tr;
    stopped = 1'b1;
    cur_ins = ins;
    op = ins[6:0];
    wait_ph(fw, FETCH, mk(0,0,0,0,0,1,0,0,1,0,0,0), mk(1,1,0,0,0,1,0,0,1,0,0,0), "FETCH", tr);
    if (tr) return;
    cyc(rnd(), DECODE, mk(0,0,0,0,0,0,0,2,2,0,0,0), "DECODE");
    case (op)
      OP_R:      ex = mk(0,0,0,0,0,0,0,1,0,2,0,0);
      OP_I:      ex = mk(0,0,0,0,0,0,0,1,2,2,0,0);
      OP_L, OP_S: ex = mk(0,0,0,0,0,0,0,1,2,0,0,0);
      OP_B:      ex = mk(0,0,1,1,0,0,0,1,0,1,0,0);
      OP_JAL:    ex = mk(0,1,0,1,0,0,0,0,0,0,1,2);
      OP_JALR:   ex = mk(0,1,0,0,0,0,0,1,2,0,1,2);
      OP_LUI:    ex = mk(0,0,0,0,0,0,0,0,2,3,0,0);
      OP_AUIPC:  ex = mk(0,0,0,0,0,0,0,2,2,0,0,0);
      default: begin
        ill_m = 1'b1;
        return;
      end
    endcase
    cyc(rnd(), EXEC, ex, "EXEC");
    if (op == OP_B || op == OP_JAL || op == OP_JALR) begin
      ret_m = ret_m + 1;
      stopped = 1'b0;
      return;
    end
    if (op == OP_L || op == OP_S) begin
      ex = (op == OP_L) ? mk(0,0,0,0,1,1,0,0,0,0,0,0) : mk(0,0,0,0,1,0,1,0,0,0,0,0);
      if (rst_mem >= 0) begin
        for (int k = 0; k < rst_mem; k++) cyc(1'b0, MEM, ex, "MEM");
        do_reset();
        return;
      end
      wait_ph(mw, MEM, ex, ex, "MEM", tr);
      if (tr) return;
      if (op == OP_S) begin
        ret_m = ret_m + 1;
        stopped = 1'b0;
        return;
      end
    end
    cyc(rnd(), WB, (op == OP_L) ? mk(0,0,0,0,0,0,0,0,0,0,1,0) : mk(0,0,0,0,0,0,0,0,0,0,1,1), "WB");
    ret_m = ret_m + 1;
    stopped = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a.st  = state;
        a.ctl = {ir_write, pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                 alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg};
        a.ret = retired;
        a.ill = illegal_instr;
        a.tmo = mem_timeout;
        n_chk++;
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s t=%0t: got st=%0d ctl=%h ret=%0d ill=%b tmo=%b, want st=%0d ctl=%h ret=%0d ill=%b tmo=%b",
                   e.tag, $time, a.st, a.ctl, a.ret, a.ill, a.tmo,
                   e.v.st, e.v.ctl, e.v.ret, e.v.ill, e.v.tmo);
        end
      end
    end
  end

  initial begin : stimulus
    logic        s;
    logic [31:0] r;
    logic [6:0]  ops [9];
    int          fw, mw;
    ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

    do_reset();
    run(32'h00500093, 0, 0, -1, s);   // addi x1,x0,5
    run(32'h0000A103, 0, 3, -1, s);   // lw, 3 busy cycles in MEM
    run(32'h00000463, 0, 0, -1, s);   // beq
    run(32'h000080E7, 1, 0, -1, s);   // jalr
    run(32'h0020A023, 2, 1, -1, s);   // sw

    for (int i = 0; i < 40; i++) begin
      r  = $urandom();
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) fw = LIMIT;
      if ($urandom_range(0, 9) == 0) mw = LIMIT;
      run({r[31:7], ops[$urandom_range(0, 8)]}, fw, mw, -1, s);
    end

    run(32'h0000007F, 0, 0, -1, s);   // unknown opcode
    trap_hold(20);
    do_reset();
    run(32'h00000031, 0, 0, -1, s);   // R opcode with low bits 01
    trap_hold(3);
    do_reset();

    run(32'h00500093, LIMIT + 1, 0, -1, s);   // fetch never completes
    trap_hold(5);
    do_reset();
    run(32'h00500093, LIMIT, 0, -1, s);       // ready exactly on the limit cycle
    run(32'h0000A103, 0, LIMIT + 1, -1, s);   // load timeout in MEM
    trap_hold(4);
    do_reset();

    run(32'h00500093, 0, 0, -1, s);
    run(32'h0020A023, 0, 0, 2, s);            // reset falls during store MEM
    run(32'h00500093, 0, 0, -1, s);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
